// File: rtl/mod_add_rr_sched_if.sv
// -----------------------------------------------------------------------------
// mod_add_rr_sched_if
// Request/response bundle for the shared modular-add scheduler.
//   req_valid/req_ready : per-requester operand handshake (ready is one-hot)
//   req_a/req_b         : packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid/rsp_ready : result handshake towards the accumulators
//   rsp_id/rsp_data     : requester index and (A+B) mod M
//   rsp_err             : an operand was >= M when it was issued
// Modports: master = issue logic + accumulator side, slave = scheduler.
// -----------------------------------------------------------------------------
interface mod_add_rr_sched_if #(
  parameter int DATA_WIDTH = 18,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_W-1:0]               rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_err;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/mod_add_rr_sched.sv
// -----------------------------------------------------------------------------
// mod_add_rr_sched
// Round-robin scheduler sharing one 2-stage modular adder between NUM_REQ
// requesters. One operand pair is granted per cycle; its requester ID travels
// with it through the pipe.
//   S1: A+B and A+B-M computed in parallel, plus id/err/valid.
//   S2: output register; picks A+B when A+B-M went negative.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mod_add_rr_sched_if.slave (request and response handshakes)
//   busy  : any pipeline stage holds a valid entry
// -----------------------------------------------------------------------------
module mod_add_rr_sched #(
  parameter int DATA_WIDTH = 18,
  parameter int MODULUS    = 177147,
  parameter int NUM_REQ    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mod_add_rr_sched_if.slave       bus,
  output logic                    busy
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [DATA_WIDTH-1:0] MOD_DW = DATA_WIDTH'(MODULUS);
  localparam logic [DATA_WIDTH+1:0] MOD_X  = (DATA_WIDTH+2)'(MODULUS);
  localparam logic [ID_W-1:0]       LAST_ID = ID_W'(NUM_REQ - 1);

  // State
  logic [ID_W-1:0]       ptr_q,       ptr_d;
  logic                  s1_valid_q,  s1_valid_d;
  logic [DATA_WIDTH:0]   s1_sum_q,    s1_sum_d;
  logic [DATA_WIDTH+1:0] s1_dif_q,    s1_dif_d;
  logic [ID_W-1:0]       s1_id_q,     s1_id_d;
  logic                  s1_err_q,    s1_err_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic [ID_W-1:0]       rsp_id_q,    rsp_id_d;
  logic                  rsp_err_q,   rsp_err_d;

  // Arbitration
  logic                  stall;
  logic                  grant_any;
  logic [ID_W-1:0]       grant_idx;
  logic [NUM_REQ-1:0]    grant;
  logic [DATA_WIDTH-1:0] a_sel, b_sel;

  // NOTE: every signal assigned in an always_comb gets a default at the top of
  // the block, so no path through it can leave a value unassigned (no latches).
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_t;
    stall     = rsp_valid_q & ~bus.rsp_ready;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    idx_t     = '0;
    // Search from ptr upward, wrapping at NUM_REQ-1; first valid wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_t = ID_W'(idx);
      if (!stall && !grant_any && bus.req_valid[idx_t]) begin
        grant_any    = 1'b1;
        grant_idx    = idx_t;
        grant[idx_t] = 1'b1;
      end
    end
  end

  assign bus.req_ready = grant;
  assign a_sel = bus.req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign b_sel = bus.req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    ptr_d       = ptr_q;
    s1_valid_d  = s1_valid_q;
    s1_sum_d    = s1_sum_q;
    s1_dif_d    = s1_dif_q;
    s1_id_d     = s1_id_q;
    s1_err_d    = s1_err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;

    if (!stall) begin
      // S1: both candidate results; the sign of A+B-M picks one in S2.
      s1_valid_d = grant_any;
      if (grant_any) begin
        s1_sum_d = {1'b0, a_sel} + {1'b0, b_sel};
        s1_dif_d = {1'b0, s1_sum_d} - MOD_X;
        s1_id_d  = grant_idx;
        s1_err_d = (a_sel >= MOD_DW) | (b_sel >= MOD_DW);
        ptr_d    = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
      end
      // S2: an empty S1 drains into an empty output slot.
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_data_d = s1_dif_q[DATA_WIDTH+1] ? s1_sum_q[DATA_WIDTH-1:0]
                                            : s1_dif_q[DATA_WIDTH-1:0];
        rsp_id_d   = s1_id_q;
        rsp_err_d  = s1_err_q;
      end
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples its pre-edge inputs regardless of statement order.
  // NOTE: the datapath registers are reset as well as the valids because the
  // response port must read all-zero out of reset; there are no arrays here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_dif_q    <= '0;
      s1_id_q     <= '0;
      s1_err_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_dif_q    <= s1_dif_d;
      s1_id_q     <= s1_id_d;
      s1_err_q    <= s1_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = s1_valid_q | rsp_valid_q;
endmodule

// File: tb/tb_mod_add_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_mod_add_rr_sched
// Self-checking bench for mod_add_rr_sched: directed scenarios followed by a
// randomized run against a transaction-level reference model.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling
// edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mod_add_rr_sched;
  localparam int DW  = 18;
  localparam int M   = 177147;
  localparam int N   = 4;
  localparam int IDW = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic           err;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   passed = 0;
  int   total  = 0;

  // Reference model: two result slots plus the round-robin pointer.
  int   m_ptr;
  bit   m_s1_v, m_out_v;
  ent_t m_s1, m_out;

  mod_add_rr_sched_if #(.DATA_WIDTH(DW), .NUM_REQ(N)) bus ();

  mod_add_rr_sched #(.DATA_WIDTH(DW), .MODULUS(M), .NUM_REQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // (A+B) mod M for in-range operands; out-of-range follows the same
  // single-subtraction rule truncated to DW bits.
  function automatic logic [DW-1:0] ref_mod(input longint a, input longint b);
    longint s;
    s = a + b;
    if (s < M) return DW'(s);
    return DW'(s - M);
  endfunction

  function automatic logic ref_err(input longint a, input longint b);
    return (a >= M) || (b >= M);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.req_a[i*DW +: DW] = a;
    bus.req_b[i*DW +: DW] = b;
  endtask

  // Present one operand pair on requester i for a single cycle.
  task automatic issue(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    set_op(i, a, b);
    bus.req_valid = N'(1) << i;
    tick();
    bus.req_valid = '0;
  endtask

  // Wait (bounded) for rsp_valid; returns positioned at a falling edge.
  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic apply_reset;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    m_ptr   = 0;
    m_s1_v  = 1'b0;
    m_out_v = 1'b0;
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_data} !== '0)
      $display("FAIL reset_outputs: got v=%b e=%b id=%0d d=%0d required all 0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_data);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy);
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_wrap;
    set_op(0, DW'(177146), DW'(1));
    bus.req_valid = 4'b0001;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0001) $display("FAIL wrap_grant: got %b required 0001", bus.req_ready);
    else passed++;
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL wrap_s1: got rsp_valid=%b busy=%b required 0/1", bus.rsp_valid, busy);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 0 || bus.rsp_id !== 0 || bus.rsp_err !== 1'b0)
      $display("FAIL wrap_result: got v=%b d=%0d id=%0d e=%b required 1/0/0/0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL wrap_drain: got rsp_valid=%b busy=%b required 0/0", bus.rsp_valid, busy);
    else passed++;
    tick();
  endtask

  task automatic test_reduce;
    bit got;
    issue(2, DW'(100000), DW'(100000));
    wait_rsp(got);
    total++;
    if (!got || bus.rsp_data !== 22853 || bus.rsp_id !== 2 || bus.rsp_err !== 1'b0)
      $display("FAIL reduce_big: got valid=%b d=%0d id=%0d e=%b required 22853 id 2 e 0",
               got, bus.rsp_data, bus.rsp_id, bus.rsp_err);
    else passed++;
    tick();
    issue(2, DW'(5), DW'(7));
    wait_rsp(got);
    total++;
    if (!got || bus.rsp_data !== 12 || bus.rsp_id !== 2)
      $display("FAIL reduce_small: got valid=%b d=%0d id=%0d required 12 id 2",
               got, bus.rsp_data, bus.rsp_id);
    else passed++;
    tick();
  endtask

  task automatic test_range_err;
    bit got;
    issue(1, DW'(177147), DW'(0));
    wait_rsp(got);
    total++;
    if (!got || bus.rsp_err !== 1'b1 || bus.rsp_data !== 0 || bus.rsp_id !== 1)
      $display("FAIL range_err: got valid=%b e=%b d=%0d id=%0d required e=1 d=0 id=1",
               got, bus.rsp_err, bus.rsp_data, bus.rsp_id);
    else passed++;
    tick();
    issue(1, DW'(3), DW'(4));
    wait_rsp(got);
    total++;
    if (!got || bus.rsp_err !== 1'b0 || bus.rsp_data !== 7)
      $display("FAIL range_ok: got valid=%b e=%b d=%0d required e=0 d=7",
               got, bus.rsp_err, bus.rsp_data);
    else passed++;
    tick();
  endtask

  task automatic test_fairness;
    logic [DW-1:0] a [N];
    logic [DW-1:0] b [N];
    apply_reset();
    for (int i = 0; i < N; i++) begin
      a[i] = DW'($urandom_range(0, M - 1));
      b[i] = DW'($urandom_range(0, M - 1));
      set_op(i, a[i], b[i]);
    end
    bus.req_valid = '1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (cyc < 6) begin
        total++;
        if (bus.req_ready !== (N'(1) << (cyc % N)))
          $display("FAIL fair_grant[%0d]: got %b required %b", cyc, bus.req_ready, N'(1) << (cyc % N));
        else passed++;
      end
      if (cyc >= 2) begin
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'((cyc - 2) % N)
            || bus.rsp_data !== ref_mod(a[(cyc-2)%N], b[(cyc-2)%N]))
          $display("FAIL fair_rsp[%0d]: got v=%b id=%0d d=%0d required id=%0d d=%0d", cyc,
                   bus.rsp_valid, bus.rsp_id, bus.rsp_data, (cyc - 2) % N,
                   ref_mod(a[(cyc-2)%N], b[(cyc-2)%N]));
        else passed++;
      end
      tick();
      if (cyc == 5) bus.req_valid = '0;
    end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] a [6];
    logic [DW-1:0] b [6];
    logic [DW-1:0] held_data;
    logic [IDW-1:0] held_id;
    int  sent = 0, rcvd = 0, cyc = 0, stalls = 0;
    bit  was_stall = 0, stall_now, grant_now;
    for (int i = 0; i < 6; i++) begin
      a[i] = DW'($urandom_range(0, M - 1));
      b[i] = DW'($urandom_range(0, M - 1));
    end
    held_data     = '0;
    held_id       = '0;
    bus.rsp_ready = 1'b1;
    set_op(1, a[0], b[0]);
    bus.req_valid = 4'b0010;
    while (rcvd < 6 && cyc < 60) begin
      @(negedge clk);
      stall_now = (bus.rsp_valid === 1'b1) && !bus.rsp_ready;
      if (stall_now) begin
        stalls++;
        total++;
        if (bus.req_ready !== '0) $display("FAIL bp_ready_in_stall: got %b required 0000", bus.req_ready);
        else passed++;
        if (was_stall) begin
          total++;
          if (bus.rsp_data !== held_data || bus.rsp_id !== held_id)
            $display("FAIL bp_stable: got d=%0d id=%0d required d=%0d id=%0d",
                     bus.rsp_data, bus.rsp_id, held_data, held_id);
          else passed++;
        end
      end
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready) begin
        total++;
        if (bus.rsp_data !== ref_mod(a[rcvd], b[rcvd]) || bus.rsp_id !== 1)
          $display("FAIL bp_order[%0d]: got d=%0d id=%0d required d=%0d id=1", rcvd,
                   bus.rsp_data, bus.rsp_id, ref_mod(a[rcvd], b[rcvd]));
        else passed++;
        rcvd++;
      end
      grant_now = bus.req_ready[1] && bus.req_valid[1];
      was_stall = stall_now;
      held_data = bus.rsp_data;
      held_id   = bus.rsp_id;
      tick();
      cyc++;
      if (grant_now) begin
        sent++;
        if (sent < 6) set_op(1, a[sent], b[sent]);
        else bus.req_valid = '0;
      end
      bus.rsp_ready = !(cyc >= 3 && cyc < 8);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    total++;
    if (rcvd != 6 || sent != 6 || stalls < 4)
      $display("FAIL bp_count: got rcvd=%0d sent=%0d stalls=%0d required 6/6/>=4", rcvd, sent, stalls);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL bp_no_dup: got rsp_valid=%b busy=%b required 0/0", bus.rsp_valid, busy);
    else passed++;
    tick();
  endtask

  task automatic test_reset_midop;
    bus.rsp_ready = 1'b1;
    issue(0, DW'(11), DW'(22));
    issue(1, DW'(33), DW'(44));
    total++;
    if (bus.rsp_valid !== 1'b1 || busy !== 1'b1)
      $display("FAIL midop_inflight: got rsp_valid=%b busy=%b required 1/1", bus.rsp_valid, busy);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL midop_flush: got rsp_valid=%b busy=%b required 0/0", bus.rsp_valid, busy);
    else passed++;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL midop_no_emit: got %b required 0", bus.rsp_valid);
    else passed++;
    tick();
    set_op(0, DW'(1), DW'(2));
    set_op(3, DW'(3), DW'(4));
    bus.req_valid = 4'b1001;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0001) $display("FAIL midop_ptr0: got %b required 0001", bus.req_ready);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b1000) $display("FAIL midop_next: got %b required 1000", bus.req_ready);
    else passed++;
    tick();
    bus.req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_random;
    logic [N-1:0] exp_ready;
    logic [DW-1:0] ga, gb;
    bit stall;
    int g, idx;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) set_op(i, DW'($urandom), DW'($urandom));
        else set_op(i, DW'($urandom_range(0, M - 1)), DW'($urandom_range(0, M - 1)));
      end
      bus.req_valid = N'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      stall     = m_out_v && !bus.rsp_ready;
      exp_ready = '0;
      g         = -1;
      if (!stall) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && bus.req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      total++;
      if (bus.req_ready !== exp_ready)
        $display("FAIL rnd_grant[%0d]: got %b required %b", cyc, bus.req_ready, exp_ready);
      else passed++;
      total++;
      if (bus.rsp_valid !== m_out_v || busy !== (m_out_v || m_s1_v))
        $display("FAIL rnd_valid[%0d]: got v=%b busy=%b required v=%b busy=%b", cyc,
                 bus.rsp_valid, busy, m_out_v, m_out_v || m_s1_v);
      else passed++;
      if (m_out_v) begin
        total++;
        if ({bus.rsp_id, bus.rsp_data, bus.rsp_err} !== m_out)
          $display("FAIL rnd_rsp[%0d]: got id=%0d d=%0d e=%b required id=%0d d=%0d e=%b", cyc,
                   bus.rsp_id, bus.rsp_data, bus.rsp_err, m_out.id, m_out.data, m_out.err);
        else passed++;
      end
      // Advance the model across the coming edge.
      if (!stall) begin
        m_out_v = m_s1_v;
        m_out   = m_s1;
        m_s1_v  = (g >= 0);
        if (g >= 0) begin
          ga      = bus.req_a[g*DW +: DW];
          gb      = bus.req_b[g*DW +: DW];
          m_s1.id   = IDW'(g);
          m_s1.data = ref_mod(ga, gb);
          m_s1.err  = ref_err(ga, gb);
          m_ptr     = (g + 1) % N;
        end
      end
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_reduce();
    test_range_err();
    test_fairness();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
